simple_cnn_engine: RTL and testbench
====================================

Name: simple_cnn_engine

Overview:
- Parametrised binary-image classifier: one conv layer (N_KERN kernels, KxK, stride 1, no padding, ReLU), then one fully-connected layer (N_CLASS outputs), then argmax.
- Successor to the fixed 5x5 classifier. Adds generic image, kernel, channel and class sizes, runtime weight ports, a BUSY/DONE handshake and score reporting.
- Uses a single serial MAC: one multiply-accumulate per cycle. Sits between the image capture front end and the result register bank.

Parameters:
- IMG_W, 5, image width in pixels (binary pixels)
- IMG_H, 5, image height
- K, 3, kernel side; K <= IMG_W and K <= IMG_H
- N_KERN, 2, number of conv kernels
- N_CLASS, 10, number of classes; N_CLASS >= 2
- WB, 8, signed weight width (conv and FC)
- FEAT_W, 8, unsigned feature width after ReLU and saturation
- ACC_W, 24, signed accumulator/score width
- Derived: OW = IMG_W-K+1; OH = IMG_H-K+1; N_FEAT = N_KERN*OH*OW; CLS_W = clog2(N_CLASS)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- START  in  1  start request; sampled only in IDLE
- IMGIN  in  IMG_W*IMG_H  image; pixel (x,y) at bit y*IMG_W+x; captured on the accepted START cycle
- CONV_W  in  N_KERN*K*K*WB  conv weights; kernel k, tap (i,j) at slice ((k*K+j)*K+i)*WB; held static while BUSY
- FC_W  in  N_CLASS*N_FEAT*WB  FC weights; class c, feature f at slice (c*N_FEAT+f)*WB; held static while BUSY
- BUSY  out  1  high in CONV and FC states
- DONE  out  1  one-cycle pulse when the result is valid
- OUT  out  CLS_W  winning class index
- SCORE  out  ACC_W  FC score of the winning class

Behaviour:
- Reset (nRST low at a CLK edge): state=IDLE. BUSY=0, DONE=0, OUT=0, SCORE=0. Counters, accumulators and the image register are cleared. Applies mid-operation; an aborted run produces no DONE.
- State IDLE: on START=1, latch IMGIN, clear counters, go to CONV.
- State CONV:
  - Loop order: kernel k, then oy, then ox, then tap j, then tap i (i fastest).
  - Each cycle: acc += (pixel(ox+i, oy+j) ? w : 0).
  - On the last tap, the feature is ReLU'd and saturated: value 0 if acc<=0, else min(acc, 2^FEAT_W-1). It is written to the feature buffer at f = k*OH*OW + oy*OW + ox, and acc is cleared.
  - After the last feature, go to FC.
- State FC:
  - Per class c, N_FEAT cycles: acc += feat[f] * w(c,f), computed as an unsigned x signed product in full precision.
  - On the last f, compare acc with the best score. c=0 always loads. For c>0, load only if acc > best (strict), so ties keep the lowest index.
  - After class N_CLASS-1, go to DONE_ST.
- State DONE_ST, one cycle: OUT and SCORE are updated from the best registers, DONE=1, BUSY=0. Next state is IDLE.
- Latency: DONE is high exactly N_KERN*OH*OW*K*K + N_CLASS*N_FEAT + 1 cycles after the START-accept edge. With defaults: 162 + 180 + 1 = 343.
- OUT and SCORE hold their values until the next DONE or reset.
- START while BUSY or in DONE_ST: ignored; no queueing. START in the IDLE cycle right after DONE is accepted.
- Accumulator overflow wraps at ACC_W (two's complement). The default ACC_W is sized so that wrap cannot occur at default parameters.

Optional Feature:
- Macro: SIMPLE_CNN_ENGINE_ABORT_EN.
- Defined: adds input port ABORT (1 bit).
  - ABORT=1 in CONV or FC: next state is IDLE, BUSY=0, no DONE pulse, OUT and SCORE unchanged.
  - Priority: nRST > ABORT > normal progression. ABORT in IDLE or DONE_ST has no effect; DONE still pulses.
- Undefined: no ABORT port; a run can only be stopped by reset.

Test Plan:
- Image all 0, any weights, START pulse -> BUSY for 342 cycles; DONE at cycle 343; OUT=0, SCORE=0 (tie resolves to index 0).
- Image all 1, conv weights all +1, FC class 3 weights all +2, other classes +1 -> each feature = 9; SCORE=18*9*2=324; OUT=3.
- Saturation: image all 1, conv weights all +127 -> acc=1143 saturates to feature 255. Conv weights all -5 -> feature 0 (ReLU).
- START re-asserted at cycles 10 and 342 of a run -> single DONE at 343. START at cycle 344 (IDLE) -> accepted; second DONE at cycle 344+343.
- nRST low at cycle 100 of a run -> next edge: BUSY=0, DONE=0, OUT=0, SCORE=0, and no DONE follows. Then START -> full 343-cycle run.
- With SIMPLE_CNN_ENGINE_ABORT_EN: ABORT at cycle 200 -> IDLE, no DONE, OUT/SCORE keep the previous result. Without the macro: the same stimulus completes normally.

Source files
------------

// File: rtl/simple_cnn_engine.sv
// Binary-image classifier: one KxK conv layer with ReLU, one FC layer and argmax, all on a single serial MAC.
// Define SIMPLE_CNN_ENGINE_ABORT_EN to add an ABORT input that cancels a run in progress.
module simple_cnn_engine #(
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int K       = 3,
  parameter int N_KERN  = 2,
  parameter int N_CLASS = 10,
  parameter int WB      = 8,
  parameter int FEAT_W  = 8,
  parameter int ACC_W   = 24
) (
  input  logic                                                       CLK,
  input  logic                                                       nRST,
  input  logic                                                       START,
`ifdef SIMPLE_CNN_ENGINE_ABORT_EN
  input  logic                                                       ABORT,
`endif
  input  logic [IMG_W*IMG_H-1:0]                                     IMGIN,
  input  logic [N_KERN*K*K*WB-1:0]                                   CONV_W,
  input  logic [N_CLASS*N_KERN*(IMG_H-K+1)*(IMG_W-K+1)*WB-1:0]       FC_W,
  output logic                                                       BUSY,
  output logic                                                       DONE,
  output logic [$clog2(N_CLASS)-1:0]                                 OUT,
  output logic [ACC_W-1:0]                                           SCORE
);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OW     = IMG_W - K + 1;
  localparam int OH     = IMG_H - K + 1;
  localparam int N_FEAT = N_KERN * OH * OW;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int N_CW   = N_KERN * K * K;
  localparam int N_FW   = N_CLASS * N_FEAT;
  localparam int CLS_W  = $clog2(N_CLASS);
  localparam int KI_W   = idx_w(K);
  localparam int KN_W   = idx_w(N_KERN);
  localparam int OX_W   = idx_w(OW);
  localparam int OY_W   = idx_w(OH);
  localparam int F_W    = idx_w(N_FEAT);
  localparam int PIX_W  = idx_w(N_PIX);
  localparam int CW_W   = idx_w(N_CW);
  localparam int FW_W   = idx_w(N_FW);
  localparam int PROD_W = FEAT_W + WB + 1;

  localparam logic signed [ACC_W-1:0] FEAT_MAX = ACC_W'((2 ** FEAT_W) - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONV    = 2'd1;
  localparam logic [1:0] FC      = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  logic [1:0]              state_reg;
  logic [N_PIX-1:0]        img_reg;
  logic [KI_W-1:0]         i_reg;
  logic [KI_W-1:0]         j_reg;
  logic [OX_W-1:0]         ox_reg;
  logic [OY_W-1:0]         oy_reg;
  logic [KN_W-1:0]         k_reg;
  logic [F_W-1:0]          f_reg;
  logic [CLS_W-1:0]        c_reg;
  logic [FW_W-1:0]         fw_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] best_reg;
  logic [CLS_W-1:0]        best_idx_reg;
  logic                    done_reg;
  logic [CLS_W-1:0]        out_reg;
  logic [ACC_W-1:0]        score_reg;

  logic [FEAT_W-1:0]       feat_mem [N_FEAT];
  logic signed [WB-1:0]    conv_w_arr [N_CW];
  logic signed [WB-1:0]    fc_w_arr [N_FW];

  logic                    abort_hit;
  logic                    i_last, j_last, ox_last, oy_last, k_last, f_last, c_last;
  logic                    tap_last, feat_last, feat_we, better;
  logic [PIX_W-1:0]        pix_idx;
  logic [CW_W-1:0]         cw_idx;
  logic signed [WB-1:0]    conv_w_cur;
  logic signed [WB-1:0]    fc_w_cur;
  logic [FEAT_W-1:0]       feat_rd;
  logic [FEAT_W-1:0]       feat_val;
  logic signed [ACC_W-1:0] conv_sum;
  logic signed [PROD_W-1:0] fc_prod;
  logic signed [ACC_W-1:0] fc_sum;

`ifdef SIMPLE_CNN_ENGINE_ABORT_EN
  assign abort_hit = ABORT;
`else
  assign abort_hit = 1'b0;
`endif

  // Flat weight buses viewed as per-tap / per-feature arrays.
  for (genvar gi = 0; gi < N_CW; gi++) begin : g_conv_w
    assign conv_w_arr[gi] = CONV_W[gi*WB +: WB];
  end
  for (genvar gi = 0; gi < N_FW; gi++) begin : g_fc_w
    assign fc_w_arr[gi] = FC_W[gi*WB +: WB];
  end

  always_comb begin
    i_last    = (i_reg == KI_W'(K - 1));
    j_last    = (j_reg == KI_W'(K - 1));
    ox_last   = (ox_reg == OX_W'(OW - 1));
    oy_last   = (oy_reg == OY_W'(OH - 1));
    k_last    = (k_reg == KN_W'(N_KERN - 1));
    f_last    = (f_reg == F_W'(N_FEAT - 1));
    c_last    = (c_reg == CLS_W'(N_CLASS - 1));
    tap_last  = i_last && j_last;
    feat_last = tap_last && ox_last && oy_last && k_last;
    feat_we   = (state_reg == CONV) && tap_last && !abort_hit;

    pix_idx    = PIX_W'((int'(oy_reg) + int'(j_reg)) * IMG_W + int'(ox_reg) + int'(i_reg));
    cw_idx     = CW_W'((int'(k_reg) * K + int'(j_reg)) * K + int'(i_reg));
    conv_w_cur = conv_w_arr[cw_idx];
    fc_w_cur   = fc_w_arr[fw_reg];
    feat_rd    = feat_mem[f_reg];

    conv_sum = acc_reg + (img_reg[pix_idx] ? {{(ACC_W-WB){conv_w_cur[WB-1]}}, conv_w_cur}
                                           : {ACC_W{1'b0}});
    // ReLU then clamp to the unsigned feature range.
    if (conv_sum <= 0) begin
      feat_val = '0;
    end else if (conv_sum > FEAT_MAX) begin
      feat_val = {FEAT_W{1'b1}};
    end else begin
      feat_val = conv_sum[FEAT_W-1:0];
    end

    fc_prod = $signed({1'b0, feat_rd}) * fc_w_cur;
    fc_sum  = acc_reg + {{(ACC_W-PROD_W){fc_prod[PROD_W-1]}}, fc_prod};
    better  = (c_reg == '0) || (fc_sum > best_reg);
  end

  // Feature buffer is scratch storage and needs no reset.
  always_ff @(posedge CLK) begin
    if (feat_we) begin
      feat_mem[f_reg] <= feat_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      img_reg      <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      ox_reg       <= '0;
      oy_reg       <= '0;
      k_reg        <= '0;
      f_reg        <= '0;
      c_reg        <= '0;
      fw_reg       <= '0;
      acc_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      done_reg     <= 1'b0;
      out_reg      <= '0;
      score_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            img_reg   <= IMGIN;
            i_reg     <= '0;
            j_reg     <= '0;
            ox_reg    <= '0;
            oy_reg    <= '0;
            k_reg     <= '0;
            f_reg     <= '0;
            c_reg     <= '0;
            fw_reg    <= '0;
            acc_reg   <= '0;
            state_reg <= CONV;
          end
        end
        CONV: begin
          if (abort_hit) begin
            state_reg <= IDLE;
          end else if (!i_last) begin
            i_reg   <= i_reg + 1'b1;
            acc_reg <= conv_sum;
          end else if (!j_last) begin
            i_reg   <= '0;
            j_reg   <= j_reg + 1'b1;
            acc_reg <= conv_sum;
          end else begin
            // Window finished: f_reg doubles as the feature write pointer.
            i_reg   <= '0;
            j_reg   <= '0;
            acc_reg <= '0;
            f_reg   <= feat_last ? '0 : f_reg + 1'b1;
            if (!ox_last) begin
              ox_reg <= ox_reg + 1'b1;
            end else begin
              ox_reg <= '0;
              if (!oy_last) begin
                oy_reg <= oy_reg + 1'b1;
              end else begin
                oy_reg <= '0;
                if (!k_last) begin
                  k_reg <= k_reg + 1'b1;
                end else begin
                  state_reg <= FC;
                end
              end
            end
          end
        end
        FC: begin
          if (abort_hit) begin
            state_reg <= IDLE;
          end else begin
            fw_reg <= fw_reg + 1'b1;
            if (!f_last) begin
              f_reg   <= f_reg + 1'b1;
              acc_reg <= fc_sum;
            end else begin
              f_reg   <= '0;
              acc_reg <= '0;
              if (better) begin
                best_reg     <= fc_sum;
                best_idx_reg <= c_reg;
              end
              if (!c_last) begin
                c_reg <= c_reg + 1'b1;
              end else begin
                state_reg <= DONE_ST;
              end
            end
          end
        end
        DONE_ST: begin
          done_reg  <= 1'b1;
          out_reg   <= best_idx_reg;
          score_reg <= best_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY  = (state_reg == CONV) || (state_reg == FC);
  assign DONE  = done_reg;
  assign OUT   = out_reg;
  assign SCORE = score_reg;

endmodule

// File: tb/tb_simple_cnn_engine.sv
// Directed bench for simple_cnn_engine at default parameters: latency, argmax/score, saturation, ReLU, START filtering, reset and abort.
module tb_simple_cnn_engine;

  localparam int N_CW   = 18;
  localparam int N_FEAT = 18;
  localparam int N_FW   = 180;
  localparam int LAT    = 343;
  localparam int MAXCYC = 1000;
`ifdef SIMPLE_CNN_ENGINE_ABORT_EN
  localparam bit ABORT_BUILD = 1'b1;
`else
  localparam bit ABORT_BUILD = 1'b0;
`endif

  logic              CLK;
  logic              nRST;
  logic              START;
  logic              abort_sig;
  logic [24:0]       img;
  logic [N_CW*8-1:0] conv_w;
  logic [N_FW*8-1:0] fc_w;
  logic              BUSY;
  logic              DONE;
  logic [3:0]        OUT;
  logic [23:0]       SCORE;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int lat;
  int busy_n;
  int dones;

  simple_cnn_engine dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .START (START),
`ifdef SIMPLE_CNN_ENGINE_ABORT_EN
    .ABORT (abort_sig),
`endif
    .IMGIN (img),
    .CONV_W(conv_w),
    .FC_W  (fc_w),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OUT   (OUT),
    .SCORE (SCORE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_conv_all(input int v);
    for (int t = 0; t < N_CW; t++) conv_w[t*8 +: 8] = 8'(v);
  endtask

  task automatic set_fc_class(input int c, input int v);
    for (int f = 0; f < N_FEAT; f++) fc_w[(c*N_FEAT+f)*8 +: 8] = 8'(v);
  endtask

  // Press START, then step until DONE; optional extra START edges, reset edge or abort edge.
  task automatic run(input int restart_a, input int restart_b, input int rst_at, input int abort_at,
                     output int lat_o, output int busy_o);
    START = 1'b1;
    tick();
    START  = 1'b0;
    busy_o = BUSY ? 1 : 0;
    lat_o  = -1;
    for (int n = 1; n <= MAXCYC; n++) begin
      START     = (n == restart_a) || (n == restart_b);
      nRST      = (n == rst_at) ? 1'b0 : 1'b1;
      abort_sig = (n == abort_at);
      tick();
      START     = 1'b0;
      nRST      = 1'b1;
      abort_sig = 1'b0;
      if (n == rst_at) break;
      if (ABORT_BUILD && n == abort_at) break;
      if (BUSY) busy_o++;
      if (DONE) begin
        lat_o = n;
        break;
      end
    end
  endtask

  task automatic idle_watch(input int cycles, output int dones_o);
    dones_o = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (DONE) dones_o++;
    end
  endtask

  task automatic set_ones_weights();
    img = '1;
    set_conv_all(1);
    for (int c = 0; c < 10; c++) set_fc_class(c, (c == 3) ? 2 : 1);
  endtask

  task automatic set_pixel_weights();
    img     = '0;
    img[12] = 1'b1;
    set_conv_all(-1);
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++)
        conv_w[(j*3+i)*8 +: 8] = 8'(10*j + i + 1);
    fc_w = '0;
    set_fc_class(1, 1);
    fc_w[(4*N_FEAT+1)*8 +: 8] = 8'(6);
  endtask

  initial begin
    nRST      = 1'b0;
    START     = 1'b0;
    abort_sig = 1'b0;
    img       = '0;
    conv_w    = '0;
    fc_w      = '0;
    tick();
    tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_out", OUT, 0);
    check("rst_score", SCORE, 0);
    nRST = 1'b1;
    tick();

    // Blank image: every score 0, tie goes to class 0.
    set_ones_weights();
    img = '0;
    run(0, 0, 0, 0, lat, busy_n);
    $display("zero image: lat=%0d busy=%0d out=%0d score=%0d", lat, busy_n, OUT, $signed(SCORE));
    check("zero_lat", lat, LAT);
    check("zero_busy", busy_n, 342);
    check("zero_out", OUT, 0);
    check("zero_score", longint'($signed(SCORE)), 0);
    tick();
    check("done_pulse", DONE, 0);
    check("idle_busy", BUSY, 0);

    // All ones: features 9, class 3 doubles its score.
    set_ones_weights();
    run(0, 0, 0, 0, lat, busy_n);
    $display("ones image: lat=%0d out=%0d score=%0d", lat, OUT, $signed(SCORE));
    check("ones_lat", lat, LAT);
    check("ones_out", OUT, 3);
    check("ones_score", longint'($signed(SCORE)), 324);

    // All negative scores: class 0 still loads first and wins.
    for (int c = 0; c < 10; c++) set_fc_class(c, -(c + 1));
    run(0, 0, 0, 0, lat, busy_n);
    $display("negative: out=%0d score=%0d", OUT, $signed(SCORE));
    check("neg_out", OUT, 0);
    check("neg_score", longint'($signed(SCORE)), -162);

    // Tie between classes 5 and 7 keeps the lower index.
    for (int c = 0; c < 10; c++) set_fc_class(c, (c == 5 || c == 7) ? 3 : 1);
    run(0, 0, 0, 0, lat, busy_n);
    $display("tie: out=%0d score=%0d", OUT, $signed(SCORE));
    check("tie_out", OUT, 5);
    check("tie_score", longint'($signed(SCORE)), 486);

    // Saturation: 9*127 clamps to 255, class 1 sums 18 of them.
    set_conv_all(127);
    fc_w = '0;
    set_fc_class(1, 1);
    run(0, 0, 0, 0, lat, busy_n);
    $display("saturate: out=%0d score=%0d", OUT, $signed(SCORE));
    check("sat_out", OUT, 1);
    check("sat_score", longint'($signed(SCORE)), 4590);

    // ReLU: negative conv sums give zero features.
    set_conv_all(-5);
    run(0, 0, 0, 0, lat, busy_n);
    $display("relu: out=%0d score=%0d", OUT, $signed(SCORE));
    check("relu_out", OUT, 0);
    check("relu_score", longint'($signed(SCORE)), 0);

    // Single centre pixel exposes tap orientation and feature ordering.
    set_pixel_weights();
    run(0, 0, 0, 0, lat, busy_n);
    $display("pixel: out=%0d score=%0d", OUT, $signed(SCORE));
    check("pix_out", OUT, 4);
    check("pix_score", longint'($signed(SCORE)), 132);

    // START during the run is ignored; START right after DONE is accepted.
    set_ones_weights();
    run(10, 342, 0, 0, lat, busy_n);
    $display("restart first: lat=%0d", lat);
    check("restart_lat1", lat, LAT);
    run(0, 0, 0, 0, lat, busy_n);
    $display("restart second: lat=%0d out=%0d score=%0d", lat, OUT, $signed(SCORE));
    check("restart_lat2", lat, LAT);
    check("restart_out", OUT, 3);
    check("restart_score", longint'($signed(SCORE)), 324);

    // Reset mid-run clears outputs and cancels the result.
    set_pixel_weights();
    run(0, 0, 100, 0, lat, busy_n);
    $display("reset mid-run: busy=%0d done=%0d out=%0d score=%0d", BUSY, DONE, OUT, $signed(SCORE));
    check("mrst_busy", BUSY, 0);
    check("mrst_done", DONE, 0);
    check("mrst_out", OUT, 0);
    check("mrst_score", SCORE, 0);
    idle_watch(400, dones);
    check("mrst_nodone", dones, 0);
    run(0, 0, 0, 0, lat, busy_n);
    $display("after reset: lat=%0d out=%0d score=%0d", lat, OUT, $signed(SCORE));
    check("mrst_lat", lat, LAT);
    check("mrst_rerun_out", OUT, 4);
    check("mrst_rerun_score", longint'($signed(SCORE)), 132);

    // Abort at edge 200: cancels when the feature is built in, otherwise the run completes.
    set_ones_weights();
    run(0, 0, 0, 200, lat, busy_n);
    if (ABORT_BUILD) begin
      check("abort_busy", BUSY, 0);
      idle_watch(400, dones);
      $display("abort: dones=%0d out=%0d score=%0d", dones, OUT, $signed(SCORE));
      check("abort_nodone", dones, 0);
      check("abort_out", OUT, 4);
      check("abort_score", longint'($signed(SCORE)), 132);
    end else begin
      $display("abort ignored: lat=%0d out=%0d score=%0d", lat, OUT, $signed(SCORE));
      check("noabort_lat", lat, LAT);
      check("noabort_out", OUT, 3);
      check("noabort_score", longint'($signed(SCORE)), 324);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
